// File: rtl/serial_mod_div.sv
// Serial modulo divider: streams dividend bits MSB-first and reports dividend mod D.
// Optional quotient shift register is enabled with macro SMD_QUOTIENT_EN.
module serial_mod_div #(
  parameter int DATA_W = 1,
  parameter int MOD_W  = 4,
  parameter int CNT_W  = 8,
  parameter int QUO_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_start,
  input  logic              in_last,
  input  logic [MOD_W-1:0]  divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MOD_W-1:0]  out_rem,
  output logic              out_divisible,
  output logic              out_err,
  output logic [CNT_W-1:0]  out_bits,
  output logic [QUO_W-1:0]  out_quo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [MOD_W-1:0] d_q, d_d, r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [MOD_W-1:0] out_rem_q, out_rem_d;
  logic             out_div_q, out_div_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] out_bits_q, out_bits_d;

  logic             accept, in_frame, err_next, ge;
  logic [MOD_W-1:0] r_base, d_base, r_step;
  logic [MOD_W:0]   t;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_step;

  assign accept   = in_valid && in_ready;
  // Non-start beats seen in IDLE belong to no frame and are dropped.
  assign in_frame = accept && (in_start || state_q == S_RUN || state_q == S_ERR);
  assign err_next = in_start ? (divisor == '0) : err_q;

`ifdef SMD_QUOTIENT_EN
  logic [QUO_W-1:0] quo_q, quo_d, quo_base, quo_step, out_quo_q, out_quo_d;
`endif

  // One restoring-division step per input bit; r < D keeps one subtract enough.
  always_comb begin
    r_base = in_start ? '0 : r_q;
    d_base = in_start ? divisor : d_q;
    r_step = r_base;
    t      = '0;
    ge     = 1'b0;
`ifdef SMD_QUOTIENT_EN
    quo_base = in_start ? '0 : quo_q;
    quo_step = quo_base;
`endif
    for (int i = DATA_W-1; i >= 0; i--) begin
      t      = {r_step, in_data[i]};
      ge     = (t >= {1'b0, d_base});
      r_step = ge ? MOD_W'(t - {1'b0, d_base}) : t[MOD_W-1:0];
`ifdef SMD_QUOTIENT_EN
      quo_step = {quo_step[QUO_W-2:0], ge};
`endif
    end
    cnt_sum  = {1'b0, (in_start ? '0 : cnt_q)} + (CNT_W+1)'(DATA_W);
    cnt_step = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_DONE) begin
      if (out_ready) state_d = S_IDLE;
    end else if (accept) begin
      if (in_start)
        state_d = in_last ? S_DONE : ((divisor == '0) ? S_ERR : S_RUN);
      else if (state_q != S_IDLE && in_last)
        state_d = S_DONE;
    end
  end

  always_comb begin
    in_ready  = (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    d_d        = d_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    out_rem_d  = out_rem_q;
    out_div_d  = out_div_q;
    out_err_d  = out_err_q;
    out_bits_d = out_bits_q;
`ifdef SMD_QUOTIENT_EN
    quo_d      = quo_q;
    out_quo_d  = out_quo_q;
`endif
    if (in_frame) begin
      d_d   = d_base;
      err_d = err_next;
      cnt_d = cnt_step;
      r_d   = err_next ? r_base : r_step;
`ifdef SMD_QUOTIENT_EN
      quo_d = err_next ? quo_base : quo_step;
`endif
      if (in_last) begin
        out_rem_d  = err_next ? '0 : r_d;
        out_div_d  = !err_next && (r_d == '0);
        out_err_d  = err_next;
        out_bits_d = cnt_d;
`ifdef SMD_QUOTIENT_EN
        out_quo_d  = quo_d;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      out_rem_q  <= '0;
      out_div_q  <= 1'b0;
      out_err_q  <= 1'b0;
      out_bits_q <= '0;
    end else begin
      d_q        <= d_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      out_rem_q  <= out_rem_d;
      out_div_q  <= out_div_d;
      out_err_q  <= out_err_d;
      out_bits_q <= out_bits_d;
    end
  end

`ifdef SMD_QUOTIENT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quo_q     <= '0;
      out_quo_q <= '0;
    end else begin
      quo_q     <= quo_d;
      out_quo_q <= out_quo_d;
    end
  end
  assign out_quo = out_quo_q;
`else
  assign out_quo = '0;
`endif

  assign out_rem       = out_rem_q;
  assign out_divisible = out_div_q;
  assign out_err       = out_err_q;
  assign out_bits      = out_bits_q;

endmodule

// File: tb/tb_serial_mod_div.sv
// Bench for serial_mod_div: DUT a has DATA_W=1, DUT b has DATA_W=2; expected
// results come from whole-number division of the collected dividend.
module tb_serial_mod_div;

  typedef struct packed {
    logic [3:0]  rem;
    logic        dv;
    logic        err;
    logic [7:0]  bits;
    logic [15:0] quo;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic a_in_valid = 0, a_in_ready, a_in_start = 0, a_in_last = 0, a_out_valid, a_out_ready = 0;
  logic a_out_div, a_out_err;
  logic [0:0] a_in_data = '0;
  logic [3:0] a_divisor = '0, a_out_rem;
  logic [7:0] a_out_bits;
  logic [15:0] a_out_quo;

  logic b_in_valid = 0, b_in_ready, b_in_start = 0, b_in_last = 0, b_out_valid, b_out_ready = 0;
  logic b_out_div, b_out_err;
  logic [1:0] b_in_data = '0;
  logic [3:0] b_divisor = '0, b_out_rem;
  logic [7:0] b_out_bits;
  logic [15:0] b_out_quo;

  serial_mod_div #(.DATA_W(1), .MOD_W(4), .CNT_W(8), .QUO_W(16)) u_a (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_start(a_in_start), .in_last(a_in_last), .divisor(a_divisor),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_rem(a_out_rem),
    .out_divisible(a_out_div), .out_err(a_out_err), .out_bits(a_out_bits), .out_quo(a_out_quo));

  serial_mod_div #(.DATA_W(2), .MOD_W(4), .CNT_W(8), .QUO_W(16)) u_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_start(b_in_start), .in_last(b_in_last), .divisor(b_divisor),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_rem(b_out_rem),
    .out_divisible(b_out_div), .out_err(b_out_err), .out_bits(b_out_bits), .out_quo(b_out_quo));

  int compared = 0;
  int mismatched = 0;
  res_t qa[$];
  res_t qb[$];
  longint unsigned m_acc[2];
  int m_bits[2];
  int m_d[2];
  bit m_act[2];

  function automatic res_t observe(input int sel);
    res_t r;
    if (sel == 0) r = '{a_out_rem, a_out_div, a_out_err, a_out_bits, a_out_quo};
    else          r = '{b_out_rem, b_out_div, b_out_err, b_out_bits, b_out_quo};
    return r;
  endfunction

  function automatic res_t model_result(input int sel);
    res_t e;
    longint unsigned q;
    e.err  = (m_d[sel] == 0);
    e.rem  = e.err ? 4'd0 : 4'(m_acc[sel] % longint'(m_d[sel]));
    e.dv   = !e.err && (e.rem == 4'd0);
    e.bits = (m_bits[sel] > 255) ? 8'hFF : 8'(m_bits[sel]);
    q = e.err ? 64'd0 : m_acc[sel] / longint'(m_d[sel]);
`ifdef SMD_QUOTIENT_EN
    e.quo = q[15:0];
`else
    e.quo = (q == 64'd0) ? 16'd0 : 16'd0;
`endif
    return e;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) m_act[s] = 0;
    qa.delete();
    qb.delete();
  endtask

  // Drive one beat, wait (bounded) for acceptance, update model and scoreboard.
  task automatic beat(input int sel, input logic [1:0] data, input logic st,
                      input logic la, input logic [3:0] dv);
    int n;
    int w;
    @(negedge clock);
    if (sel == 0) begin
      a_in_valid = 1; a_in_data = data[0:0]; a_in_start = st; a_in_last = la; a_divisor = dv;
    end else begin
      b_in_valid = 1; b_in_data = data; b_in_start = st; b_in_last = la; b_divisor = dv;
    end
    n = 0;
    while (((sel == 0) ? a_in_ready : b_in_ready) !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      compared++; mismatched++;
      $display("FAIL beat_accept dut=%0d: in_ready stuck at 0, required 1", sel);
    end
    @(posedge clock);
    #1;
    if (sel == 0) a_in_valid = 0; else b_in_valid = 0;
    if (st) begin
      m_act[sel] = 1; m_acc[sel] = 0; m_bits[sel] = 0; m_d[sel] = int'(dv);
    end
    if (m_act[sel]) begin
      w = sel + 1;
      m_acc[sel]  = (m_acc[sel] << w) | ((sel == 0) ? 64'(data[0]) : 64'(data));
      m_bits[sel] += w;
      if (la) begin
        if (sel == 0) qa.push_back(model_result(0)); else qb.push_back(model_result(1));
        m_act[sel] = 0;
      end
    end
  endtask

  // Wait (bounded) for out_valid; reports cycles waited, no handshake.
  task automatic wait_result(input int sel, output res_t got, output int lat, output bit to);
    @(negedge clock);
    lat = 0;
    while (((sel == 0) ? a_out_valid : b_out_valid) !== 1'b1 && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    to  = (lat >= 50);
    got = observe(sel);
  endtask

  task automatic ack(input int sel);
    if (sel == 0) a_out_ready = 1; else b_out_ready = 1;
    @(posedge clock);
    #1;
    a_out_ready = 0;
    b_out_ready = 0;
  endtask

  function automatic res_t pop_exp(input int sel);
    res_t e;
    e = '1;
    if (sel == 0 && qa.size() > 0) e = qa.pop_front();
    if (sel == 1 && qb.size() > 0) e = qb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clock);
    compared++;
    if ({a_in_ready, a_out_valid, observe(0)} !== {2'b10, 30'd0}) begin
      mismatched++;
      $display("FAIL reset_a: got rdy=%b vld=%b res=%h, required rdy=1 vld=0 res=0",
               a_in_ready, a_out_valid, observe(0));
    end
    compared++;
    if ({b_in_ready, b_out_valid, observe(1)} !== {2'b10, 30'd0}) begin
      mismatched++;
      $display("FAIL reset_b: got rdy=%b vld=%b res=%h, required rdy=1 vld=0 res=0",
               b_in_ready, b_out_valid, observe(1));
    end
    reset = 0;
  endtask

  task automatic test_basic();
    res_t got, e; int lat; bit to;
    beat(0, 2'd1, 1, 0, 4'd3);
    beat(0, 2'd0, 0, 0, 4'd3);
    beat(0, 2'd1, 0, 0, 4'd3);
    beat(0, 2'd1, 0, 1, 4'd3);
    wait_result(0, got, lat, to);
    e = pop_exp(0);
    compared++;
    if (lat != 0 || to) begin
      mismatched++;
      $display("FAIL basic_latency: waited %0d cycles, required 0", lat);
    end
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL basic_result: got %h, required %h", got, e);
    end
    ack(0);
  endtask

  task automatic test_wide();
    res_t got, e; int lat; bit to;
    beat(1, 2'b11, 1, 0, 4'd5);
    beat(1, 2'b01, 0, 1, 4'd5);
    wait_result(1, got, lat, to);
    e = pop_exp(1);
    compared++;
    if (to || got !== e) begin
      mismatched++;
      $display("FAIL wide_result: got %h (timeout=%0d), required %h", got, to, e);
    end
    ack(1);
  endtask

  task automatic test_backpressure();
    res_t got, e, snap; int lat; bit to;
    beat(0, 2'd1, 1, 0, 4'd3);
    beat(0, 2'd1, 0, 0, 4'd3);
    beat(0, 2'd0, 0, 1, 4'd3);
    wait_result(0, got, lat, to);
    e = pop_exp(0);
    compared++;
    if (to || got !== e || got.dv !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_result: got %h, required %h", got, e);
    end
    snap = got;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      compared++;
      if ({a_out_valid, a_in_ready, observe(0)} !== {2'b10, snap}) begin
        mismatched++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b res=%h, required vld=1 rdy=0 res=%h",
                 i, a_out_valid, a_in_ready, observe(0), snap);
      end
    end
    ack(0);
    @(negedge clock);
    compared++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL bp_release: got vld=%b rdy=%b, required vld=0 rdy=1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_err();
    res_t got, e; int lat; bit to;
    beat(1, 2'b10, 1, 0, 4'd0);
    beat(1, 2'b11, 0, 0, 4'd0);
    beat(1, 2'b01, 0, 0, 4'd0);
    beat(1, 2'b11, 0, 1, 4'd0);
    wait_result(1, got, lat, to);
    e = pop_exp(1);
    compared++;
    if (to || got !== e || got.err !== 1'b1 || got.bits !== 8'd8) begin
      mismatched++;
      $display("FAIL err_result: got %h, required %h", got, e);
    end
    ack(1);
  endtask

  task automatic test_reset_abort();
    res_t got, e; int lat; bit to;
    beat(0, 2'd1, 1, 0, 4'd5);
    beat(0, 2'd1, 0, 0, 4'd5);
    @(negedge clock);
    reset = 1;
    #2 reset = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      compared++;
      if (a_out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL abort_no_result cycle %0d: out_valid=%b, required 0", i, a_out_valid);
      end
    end
    beat(0, 2'd1, 1, 0, 4'd7);
    beat(0, 2'd1, 0, 0, 4'd7);
    beat(0, 2'd1, 0, 1, 4'd7);
    wait_result(0, got, lat, to);
    e = pop_exp(0);
    compared++;
    if (to || got !== e || got.dv !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_new_frame: got %h, required %h", got, e);
    end
    // Reset while a result is pending drops it.
    @(negedge clock);
    reset = 1;
    #2 reset = 0;
    model_reset();
    @(negedge clock);
    compared++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL abort_done: got vld=%b rdy=%b, required vld=0 rdy=1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_restart();
    res_t got, e; int lat; bit to;
    beat(0, 2'd1, 1, 0, 4'd3);
    beat(0, 2'd1, 0, 0, 4'd3);
    beat(0, 2'd1, 1, 0, 4'd4);
    beat(0, 2'd0, 0, 0, 4'd4);
    beat(0, 2'd1, 0, 1, 4'd4);
    wait_result(0, got, lat, to);
    e = pop_exp(0);
    compared++;
    if (to || got !== e || got.rem !== 4'd1 || got.bits !== 8'd3) begin
      mismatched++;
      $display("FAIL restart_result: got %h, required %h", got, e);
    end
    ack(0);
  endtask

  task automatic test_idle_drop();
    res_t got, e; int lat; bit to;
    beat(0, 2'd1, 0, 1, 4'd3);
    repeat (3) begin
      @(negedge clock);
      compared++;
      if (a_out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_drop: out_valid=%b, required 0", a_out_valid);
      end
    end
    beat(0, 2'd1, 1, 1, 4'd1);
    wait_result(0, got, lat, to);
    e = pop_exp(0);
    compared++;
    if (to || got !== e || got.rem !== 4'd0) begin
      mismatched++;
      $display("FAIL single_beat_d1: got %h, required %h", got, e);
    end
    ack(0);
  endtask

  task automatic test_saturate();
    res_t got, e; int lat; bit to;
    for (int i = 0; i < 128; i++) beat(1, 2'b11, i == 0, i == 127, 4'd1);
    wait_result(1, got, lat, to);
    e = pop_exp(1);
    compared++;
    if (to || got !== e || got.bits !== 8'hFF) begin
      mismatched++;
      $display("FAIL saturate: got %h, required %h", got, e);
    end
    ack(1);
  endtask

  task automatic test_random();
    res_t got, e; int lat; bit to;
    int nb; logic [3:0] d;
    for (int f = 0; f < 24; f++) begin
      nb = $urandom_range(1, 6);
      d  = 4'($urandom_range(0, 15));
      for (int i = 0; i < nb; i++)
        beat(1, 2'($urandom_range(0, 3)), i == 0, i == nb - 1, d);
      wait_result(1, got, lat, to);
      e = pop_exp(1);
      compared++;
      if (to || lat != 0 || got !== e) begin
        mismatched++;
        $display("FAIL random frame %0d D=%0d: got %h lat=%0d, required %h lat=0", f, d, got, lat, e);
      end
      ack(1);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_wide();
    test_backpressure();
    test_err();
    test_reset_abort();
    test_restart();
    test_idle_drop();
    test_saturate();
    test_random();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
